// File: rtl/ami_response_router_if.sv
// ami_response_router_if: bundles the issue-side, memory-side and requester-side signals of
// the AMI response router.
//   Issue side     : issue_valid, issue_src, issue_is_write -> router; tag_full <- router
//   Memory side    : mem_resps -> router; mem_resp_grants <- router
//   Requester side : mem_resps_internal / mem_resps_app <- router;
//                    mem_resp_grants_internal / mem_resp_grants_app -> router
//   Status         : outstanding_internal, outstanding_app, err_overflow, err_orphan <- router
// A response word is {valid, data}: valid in the MSB, data below it.
// Modport slave is the router; modport master is its environment.
interface ami_response_router_if #(
    parameter int unsigned TAG_LOG_DEPTH = 6,
    parameter int unsigned DataWidth     = 64
);
    localparam int unsigned RespWidth = DataWidth + 1;

    logic                   issue_valid;
    logic                   issue_src;
    logic                   issue_is_write;
    logic                   tag_full;
    logic [RespWidth-1:0]   mem_resps;
    logic                   mem_resp_grants;
    logic [RespWidth-1:0]   mem_resps_internal;
    logic                   mem_resp_grants_internal;
    logic [RespWidth-1:0]   mem_resps_app;
    logic                   mem_resp_grants_app;
    logic [TAG_LOG_DEPTH:0] outstanding_internal;
    logic [TAG_LOG_DEPTH:0] outstanding_app;
    logic                   err_overflow;
    logic                   err_orphan;

    modport slave (
        input  issue_valid, issue_src, issue_is_write, mem_resps,
        input  mem_resp_grants_internal, mem_resp_grants_app,
        output tag_full, mem_resp_grants, mem_resps_internal, mem_resps_app,
        output outstanding_internal, outstanding_app, err_overflow, err_orphan
    );

    modport master (
        output issue_valid, issue_src, issue_is_write, mem_resps,
        output mem_resp_grants_internal, mem_resp_grants_app,
        input  tag_full, mem_resp_grants, mem_resps_internal, mem_resps_app,
        input  outstanding_internal, outstanding_app, err_overflow, err_orphan
    );
endinterface

// File: rtl/ami_response_router.sv
// ami_response_router: remembers the source (internal/app) of each issued read in a tag FIFO
// and steers in-order memory responses to the matching requester through a one-entry slot
// per output port.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ami_response_router_if.slave (issue, memory, requester and status signals)
module ami_response_router #(
    parameter int unsigned TAG_LOG_DEPTH = 6,
    parameter int unsigned DataWidth     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    ami_response_router_if.slave  bus
);
    localparam int unsigned Depth = 1 << TAG_LOG_DEPTH;
    localparam logic [TAG_LOG_DEPTH:0]   DepthCnt = (TAG_LOG_DEPTH + 1)'(Depth);
    localparam logic [TAG_LOG_DEPTH:0]   CntOne   = 1;
    localparam logic [TAG_LOG_DEPTH-1:0] PtrOne   = 1;

    typedef struct packed {
        logic                 valid;
        logic [DataWidth-1:0] data;
    } resp_t;

    resp_t                    mem_resp;
    resp_t                    slot_int_q, slot_int_d, slot_app_q, slot_app_d;
    logic [Depth-1:0]         tags_q, tags_d;
    logic [TAG_LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TAG_LOG_DEPTH:0]   count_q, count_d;
    logic [TAG_LOG_DEPTH:0]   out_int_q, out_int_d, out_app_q, out_app_d;
    logic                     err_overflow_q, err_overflow_d, err_orphan_q, err_orphan_d;

    logic empty, full, is_read, push, pop, head, head_routable, grant;
    logic inc_int, dec_int, inc_app, dec_app;

    assign mem_resp = resp_t'(bus.mem_resps);

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == DepthCnt);
        is_read = bus.issue_valid && !bus.issue_is_write;
        push    = is_read && !full;
        head    = tags_q[rd_ptr_q];
        // A slot can take the head response if it is free or being drained this cycle.
        head_routable = !empty && (head ? (!slot_app_q.valid || bus.mem_resp_grants_app)
                                        : (!slot_int_q.valid || bus.mem_resp_grants_internal));
        // An empty FIFO with a read being issued this cycle is not an orphan: the response
        // waits one cycle for the tag to become visible.
        grant = !rst && mem_resp.valid && (head_routable || (empty && !push));
        pop   = grant && !empty;

        tags_d   = tags_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            tags_d[wr_ptr_q] = bus.issue_src;
            wr_ptr_d         = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: ;
        endcase

        inc_int   = push && !bus.issue_src;
        inc_app   = push && bus.issue_src;
        dec_int   = pop && !head;
        dec_app   = pop && head;
        out_int_d = out_int_q;
        out_app_d = out_app_q;
        if (inc_int && !dec_int && (out_int_q != DepthCnt)) out_int_d = out_int_q + CntOne;
        if (dec_int && !inc_int && (out_int_q != '0))       out_int_d = out_int_q - CntOne;
        if (inc_app && !dec_app && (out_app_q != DepthCnt)) out_app_d = out_app_q + CntOne;
        if (dec_app && !inc_app && (out_app_q != '0))       out_app_d = out_app_q - CntOne;

        // Reload wins over drain so a port can sustain one response per cycle.
        slot_int_d = slot_int_q;
        slot_app_d = slot_app_q;
        if (bus.mem_resp_grants_internal) slot_int_d = '0;
        if (bus.mem_resp_grants_app)      slot_app_d = '0;
        if (dec_int) slot_int_d = mem_resp;
        if (dec_app) slot_app_d = mem_resp;

        err_overflow_d = err_overflow_q || (is_read && full);
        err_orphan_d   = err_orphan_q || (grant && empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags_q         <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            out_int_q      <= '0;
            out_app_q      <= '0;
            slot_int_q     <= '0;
            slot_app_q     <= '0;
            err_overflow_q <= 1'b0;
            err_orphan_q   <= 1'b0;
        end else begin
            tags_q         <= tags_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            out_int_q      <= out_int_d;
            out_app_q      <= out_app_d;
            slot_int_q     <= slot_int_d;
            slot_app_q     <= slot_app_d;
            err_overflow_q <= err_overflow_d;
            err_orphan_q   <= err_orphan_d;
        end
    end

    assign bus.tag_full             = full;
    assign bus.mem_resp_grants      = grant;
    assign bus.mem_resps_internal   = slot_int_q;
    assign bus.mem_resps_app        = slot_app_q;
    assign bus.outstanding_internal = out_int_q;
    assign bus.outstanding_app      = out_app_q;
    assign bus.err_overflow         = err_overflow_q;
    assign bus.err_orphan           = err_orphan_q;
endmodule

// File: tb/tb_ami_response_router.sv
// tb_ami_response_router: directed bench for ami_response_router. Inputs change 1 time unit
// after a rising edge; combinational grant is sampled 1 unit later, registered outputs
// 1 unit after the following edge.
module tb_ami_response_router;
    localparam int unsigned Tld = 6;
    localparam int unsigned Dw  = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    ami_response_router_if #(.TAG_LOG_DEPTH(Tld), .DataWidth(Dw)) bus ();

    ami_response_router #(.TAG_LOG_DEPTH(Tld), .DataWidth(Dw)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [Dw:0] rsp(input logic [Dw-1:0] data);
        return {1'b1, data};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic src, input logic wr);
        bus.issue_valid    = 1'b1;
        bus.issue_src      = src;
        bus.issue_is_write = wr;
        tick();
        bus.issue_valid    = 1'b0;
        bus.issue_is_write = 1'b0;
    endtask

    // Present a response, check the combinational grant, then advance one edge.
    task automatic beat(input string tag, input logic [Dw-1:0] data, input logic exp_grant);
        bus.mem_resps = rsp(data);
        #1;
        chk(tag, 128'(bus.mem_resp_grants), 128'(exp_grant));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ports(input string tag, input logic [Dw:0] e_int, input logic [Dw:0] e_app);
        chk({tag, "_int"}, 128'(bus.mem_resps_internal), 128'(e_int));
        chk({tag, "_app"}, 128'(bus.mem_resps_app), 128'(e_app));
    endtask

    task automatic chk_cnt(input string tag, input int e_int, input int e_app);
        chk({tag, "_cnt_int"}, 128'(bus.outstanding_internal), 128'(e_int));
        chk({tag, "_cnt_app"}, 128'(bus.outstanding_app), 128'(e_app));
    endtask

    task automatic chk_idle(input string tag);
        chk_ports(tag, '0, '0);
        chk_cnt(tag, 0, 0);
        chk({tag, "_full"}, 128'(bus.tag_full), 128'(0));
        chk({tag, "_ovf"}, 128'(bus.err_overflow), 128'(0));
        chk({tag, "_orph"}, 128'(bus.err_orphan), 128'(0));
        chk({tag, "_grant"}, 128'(bus.mem_resp_grants), 128'(0));
    endtask

    initial begin
        bus.issue_valid              = 1'b0;
        bus.issue_src                = 1'b0;
        bus.issue_is_write           = 1'b0;
        bus.mem_resps                = rsp(64'hDEAD);
        bus.mem_resp_grants_internal = 1'b1;
        bus.mem_resp_grants_app      = 1'b1;

        // Reset, with a valid response presented: nothing may be granted.
        #1 rst = 1'b1;
        #2 chk_idle("reset");
        tick();
        chk_idle("reset_clk");
        bus.mem_resps = '0;
        rst = 1'b0;

        // Reads 0,1,1,0 then back-to-back responses A..D.
        issue(1'b0, 1'b0);
        issue(1'b1, 1'b0);
        issue(1'b1, 1'b0);
        issue(1'b0, 1'b0);
        chk_cnt("t1_issued", 2, 2);
        beat("t1_gA", 64'hA, 1'b1);
        chk_ports("t1_A", rsp(64'hA), '0);
        beat("t1_gB", 64'hB, 1'b1);
        chk_ports("t1_B", '0, rsp(64'hB));
        beat("t1_gC", 64'hC, 1'b1);
        chk_ports("t1_C", '0, rsp(64'hC));
        beat("t1_gD", 64'hD, 1'b1);
        chk_ports("t1_D", rsp(64'hD), '0);
        bus.mem_resps = '0;
        tick();
        chk_ports("t1_drained", '0, '0);
        chk_cnt("t1_done", 0, 0);

        // App port stalls: head app tag with full app slot blocks everything behind it.
        bus.mem_resp_grants_app = 1'b0;
        issue(1'b1, 1'b0);
        issue(1'b1, 1'b0);
        issue(1'b0, 1'b0);
        beat("t2_gE", 64'hE, 1'b1);
        chk_ports("t2_E", '0, rsp(64'hE));
        beat("t2_gF_stall", 64'hF, 1'b0);
        chk_ports("t2_stall", '0, rsp(64'hE));
        chk_cnt("t2_stall", 1, 1);
        bus.mem_resp_grants_app = 1'b1;
        beat("t2_gF", 64'hF, 1'b1);
        chk_ports("t2_F", '0, rsp(64'hF));
        beat("t2_gG", 64'h6, 1'b1);
        chk_ports("t2_G", rsp(64'h6), '0);
        bus.mem_resps = '0;
        tick();
        chk_cnt("t2_done", 0, 0);

        // Read issued in the same cycle a response appears: granted one cycle later.
        bus.issue_valid = 1'b1;
        bus.issue_src   = 1'b0;
        bus.mem_resps   = rsp(64'h1234);
        #1 chk("t3_same_cycle", 128'(bus.mem_resp_grants), 128'(0));
        tick();
        bus.issue_valid = 1'b0;
        beat("t3_next_cycle", 64'h1234, 1'b1);
        chk_ports("t3_H", rsp(64'h1234), '0);
        chk("t3_no_orphan", 128'(bus.err_orphan), 128'(0));
        bus.mem_resps = '0;
        tick();

        // Writes push no tag; a response then is an orphan.
        issue(1'b0, 1'b1);
        chk_cnt("t4_write", 0, 0);
        beat("t4_gI", 64'h99, 1'b1);
        chk_ports("t4_I", '0, '0);
        chk("t4_orphan", 128'(bus.err_orphan), 128'(1));
        bus.mem_resps = '0;

        // Fill the tag FIFO, then overflow it.
        for (int i = 0; i < 64; i++) begin
            issue(logic'(i % 2), 1'b0);
        end
        chk("t5_full", 128'(bus.tag_full), 128'(1));
        chk_cnt("t5_full", 32, 32);
        chk("t5_no_ovf", 128'(bus.err_overflow), 128'(0));
        issue(1'b0, 1'b0);
        chk("t5_ovf", 128'(bus.err_overflow), 128'(1));
        chk_cnt("t5_ovf", 32, 32);
        chk("t5_still_full", 128'(bus.tag_full), 128'(1));

        // Asynchronous reset clears a full FIFO and both sticky errors.
        rst = 1'b1;
        #2 chk_idle("t6_reset_full");
        rst = 1'b0;
        tick();

        // Reset with 3 outstanding reads and a full internal slot.
        bus.mem_resp_grants_internal = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 1'b0);
        end
        beat("t6_gJ", 64'h77, 1'b1);
        bus.mem_resps = '0;
        chk_ports("t6_J", rsp(64'h77), '0);
        chk_cnt("t6_J", 3, 0);
        #2;
        bus.mem_resps = rsp(64'h55);
        rst = 1'b1;
        #1 chk_idle("t6_midreset");
        bus.mem_resps = '0;
        bus.mem_resp_grants_internal = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk_ports("t6_release", '0, '0);
        issue(1'b1, 1'b0);
        beat("t6_gK", 64'h88, 1'b1);
        chk_ports("t6_K", '0, rsp(64'h88));
        chk_cnt("t6_K", 0, 0);
        bus.mem_resps = '0;
        tick();
        chk_ports("t6_end", '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
